ppu_ex_mem_control_path: RTL and testbench
==========================================

# ppu_ex_mem_control_path

Control-path slice of the five-stage PPU pipeline between decode and memory access. It holds the 22-bit control word in the ID/EX and EX/MEM pipeline registers and breaks out the fields each stage consumes. It also provides the combinational PC+4 adder that feeds the nPC register. It sits after the control unit and the bubble mux, and before the MEM/WB register.

## Interface
- CW_WIDTH, 22, control word width; fixed for this block, not overridable.
- clk  in  1  single pipeline clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- adder_in  in  32  current nPC value.
- adder_out  out  32  adder_in + 4, combinational.
- id_control  in  22  control word from the bubble mux.
- ex_control  out  22  ID/EX registered control word.
- ex_alu_op  out  4  ex_control[14:11].
- ex_source_operand  out  3  ex_control[17:15].
- ex_branch_instr  out  1  ex_control[8].
- ex_load_instr  out  1  ex_control[10].
- ex_rf_enable  out  1  ex_control[9].
- mem_control  out  22  EX/MEM registered control word, with EX-consumed fields cleared.
- mem_size  out  2  mem_control[6:5].
- mem_rw  out  1  mem_control[4].
- mem_se  out  1  mem_control[3].
- mem_enable  out  1  mem_control[0].
- mem_load_instr  out  1  mem_control[10].
- mem_rf_enable  out  1  mem_control[9].

## Operation
- Control word bit map:
  - 21 cond/uncond, 20 r31, 19 unconditional jump, 18 destination.
  - 17:15 source operand, 14:11 ALU op.
  - 10 load, 9 RF enable, 8 branch, 7 TA.
  - 6:5 mem size, 4 mem R/W, 3 mem SE.
  - 2 HI enable, 1 LO enable, 0 mem enable.
- ID/EX register: captures id_control unchanged on each rising clk.
- EX/MEM register: captures ex_control on each rising clk with bits 21:11 and 8:7 forced to 0.
  - Bits kept: 10, 9, 6:0. Equivalent mask: 22'h00067F.
- All ex_* and mem_* field outputs are pure wire slices of their registers. No added logic.
- Adder: 32-bit unsigned add of constant 4, modulo 2^32, no carry out.
- A bubble (id_control = 0) propagates as an all-zero word. There is no stall or enable input; both registers load every cycle.

## Timing
- Reset (reset = 0): both registers clear to 0 immediately, without waiting for clk. All ex_* and mem_* outputs read 0 while reset is held.
- Reset deassertion: the first capture happens at the first rising clk after reset = 1.
- Latency:
  - id_control to ex_control: 1 cycle.
  - id_control to mem_control: 2 cycles.
  - adder_in to adder_out: 0 cycles (combinational).
- Reset asserted mid-flight: all in-flight words are discarded. There is no recovery of partial state.
- Reset released coincident with a clk edge: that edge does not load.
- Wrap-around: adder_in = 32'hFFFF_FFFC gives adder_out = 32'h0000_0000.

## Structure
- Shared package ppu_ctrl_pkg holds:
  - CW_WIDTH.
  - Bit-position constants for every control field.
  - The EX/MEM keep mask, 22'h00067F.
  - The MEM/WB stage and the control unit import the same package.
- One reusable sub-module: ppu_ctrl_pipe_reg.
  - Parameterized width and mask, async active-low clear.
  - Instantiated twice: ID/EX with mask all-ones, EX/MEM with the keep mask.
- The adder is inline combinational logic in the top level.

## Test plan
- Reset: hold reset = 0 for 3 time units, driving id_control = 22'h3FFFFF. Required: ex_control = 0 and mem_control = 0 throughout, and all field outputs are 0.
- Single word: apply id_control = 22'h2AAAAA for one cycle, then 0.
  - After edge 1: ex_control = 22'h2AAAAA, ex_source_operand = 3'b101, ex_alu_op = 4'b0101, ex_rf_enable = 1, ex_branch_instr = 0, ex_load_instr = 0.
  - After edge 2: mem_control = 22'h00022A, mem_size = 2'b01, mem_se = 1, mem_rw = 0, mem_enable = 0, mem_rf_enable = 1.
  - After edge 3: both registers are 0.
- Back-to-back words: apply 22'h155555 then 22'h2AAAAA on consecutive cycles. Required: at the second edge, ex_control = 22'h2AAAAA and mem_control = 22'h000455.
- Reset mid-flight: with both registers nonzero, pulse reset low between clock edges. Required: all outputs read 0 before the next clk edge, and reloading resumes at the first edge after release.
- Adder values:
  - adder_in = 0 → adder_out = 4.
  - adder_in = 32'h0000_0100 → adder_out = 32'h0000_0104.
  - adder_in = 32'hFFFF_FFFC → adder_out = 0.
  - Each result appears with no clock edge.
- Bubble: id_control = 0 (mux select active) for 2 cycles after nonzero traffic. Required: ex_control and mem_control both read 0 after 2 edges.

Source files
------------

// File: rtl/ppu_ctrl_pkg.sv
// Shared control-word definitions for the PPU pipeline: width, field
// bit positions and the EX/MEM keep mask.
package ppu_ctrl_pkg;

    localparam int CW_WIDTH = 22;

    localparam int CW_COND_BIT      = 21;
    localparam int CW_R31_BIT       = 20;
    localparam int CW_UNCOND_BIT    = 19;
    localparam int CW_DEST_BIT      = 18;
    localparam int CW_SRC_OP_HI     = 17;
    localparam int CW_SRC_OP_LO     = 15;
    localparam int CW_ALU_OP_HI     = 14;
    localparam int CW_ALU_OP_LO     = 11;
    localparam int CW_LOAD_BIT      = 10;
    localparam int CW_RF_EN_BIT     = 9;
    localparam int CW_BRANCH_BIT    = 8;
    localparam int CW_TA_BIT        = 7;
    localparam int CW_MEM_SIZE_HI   = 6;
    localparam int CW_MEM_SIZE_LO   = 5;
    localparam int CW_MEM_RW_BIT    = 4;
    localparam int CW_MEM_SE_BIT    = 3;
    localparam int CW_HI_EN_BIT     = 2;
    localparam int CW_LO_EN_BIT     = 1;
    localparam int CW_MEM_EN_BIT    = 0;

    // Fields still needed beyond EX: load, RF enable, memory and HI/LO controls.
    localparam logic [CW_WIDTH-1:0] CW_EX_MEM_KEEP_MASK = 22'h00067F;
    localparam logic [CW_WIDTH-1:0] CW_ALL_ONES_MASK    = 22'h3FFFFF;

endpackage

// File: rtl/ppu_ctrl_pipe_reg.sv
// Control-word pipeline register that loads every cycle, clearing the bits
// outside MASK; asynchronous active-low clear.
module ppu_ctrl_pipe_reg #(
    parameter int                 WIDTH = 22,
    parameter logic [WIDTH-1:0]   MASK  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Masked capture of the incoming control word on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= {WIDTH{1'b0}};
        end else begin
            r_q <= i_d & MASK;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ppu_ex_mem_control_path.sv
// ID/EX and EX/MEM control-word registers with per-stage field breakout,
// plus the combinational PC+4 adder feeding nPC.
module ppu_ex_mem_control_path
    import ppu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         adder_in,
    output logic [31:0]         adder_out,
    input  logic [CW_WIDTH-1:0] id_control,
    output logic [CW_WIDTH-1:0] ex_control,
    output logic [3:0]          ex_alu_op,
    output logic [2:0]          ex_source_operand,
    output logic                ex_branch_instr,
    output logic                ex_load_instr,
    output logic                ex_rf_enable,
    output logic [CW_WIDTH-1:0] mem_control,
    output logic [1:0]          mem_size,
    output logic                mem_rw,
    output logic                mem_se,
    output logic                mem_enable,
    output logic                mem_load_instr,
    output logic                mem_rf_enable
);

    ppu_ctrl_pipe_reg #(
        .WIDTH (CW_WIDTH),
        .MASK  (CW_ALL_ONES_MASK)
    ) u_id_ex_reg (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (id_control),
        .o_q   (ex_control)
    );

    // EX-consumed fields are dropped here so MEM only sees what it still needs.
    ppu_ctrl_pipe_reg #(
        .WIDTH (CW_WIDTH),
        .MASK  (CW_EX_MEM_KEEP_MASK)
    ) u_ex_mem_reg (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (ex_control),
        .o_q   (mem_control)
    );

    assign ex_alu_op         = ex_control[CW_ALU_OP_HI:CW_ALU_OP_LO];
    assign ex_source_operand = ex_control[CW_SRC_OP_HI:CW_SRC_OP_LO];
    assign ex_branch_instr   = ex_control[CW_BRANCH_BIT];
    assign ex_load_instr     = ex_control[CW_LOAD_BIT];
    assign ex_rf_enable      = ex_control[CW_RF_EN_BIT];

    assign mem_size          = mem_control[CW_MEM_SIZE_HI:CW_MEM_SIZE_LO];
    assign mem_rw            = mem_control[CW_MEM_RW_BIT];
    assign mem_se            = mem_control[CW_MEM_SE_BIT];
    assign mem_enable        = mem_control[CW_MEM_EN_BIT];
    assign mem_load_instr    = mem_control[CW_LOAD_BIT];
    assign mem_rf_enable     = mem_control[CW_RF_EN_BIT];

    // Wraps modulo 2^32; no carry out is needed by nPC.
    assign adder_out = adder_in + 32'd4;

endmodule

// File: tb/tb_ppu_ex_mem_control_path.sv
// Directed self-checking bench for ppu_ex_mem_control_path.
module tb_ppu_ex_mem_control_path;

    logic        clk;
    logic        reset;
    logic [31:0] adder_in;
    logic [31:0] adder_out;
    logic [21:0] id_control;
    logic [21:0] ex_control;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_source_operand;
    logic        ex_branch_instr;
    logic        ex_load_instr;
    logic        ex_rf_enable;
    logic [21:0] mem_control;
    logic [1:0]  mem_size;
    logic        mem_rw;
    logic        mem_se;
    logic        mem_enable;
    logic        mem_load_instr;
    logic        mem_rf_enable;

    int checks;
    int failures;

    ppu_ex_mem_control_path dut (
        .clk               (clk),
        .reset             (reset),
        .adder_in          (adder_in),
        .adder_out         (adder_out),
        .id_control        (id_control),
        .ex_control        (ex_control),
        .ex_alu_op         (ex_alu_op),
        .ex_source_operand (ex_source_operand),
        .ex_branch_instr   (ex_branch_instr),
        .ex_load_instr     (ex_load_instr),
        .ex_rf_enable      (ex_rf_enable),
        .mem_control       (mem_control),
        .mem_size          (mem_size),
        .mem_rw            (mem_rw),
        .mem_se            (mem_se),
        .mem_enable        (mem_enable),
        .mem_load_instr    (mem_load_instr),
        .mem_rf_enable     (mem_rf_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_control"},  {10'd0, ex_control}, 32'd0);
        chk({tag, "_mem_control"}, {10'd0, mem_control}, 32'd0);
        chk({tag, "_ex_fields"},
            {21'd0, ex_alu_op, ex_source_operand, ex_branch_instr, ex_load_instr, ex_rf_enable}, 32'd0);
        chk({tag, "_mem_fields"},
            {25'd0, mem_size, mem_rw, mem_se, mem_enable, mem_load_instr, mem_rf_enable}, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        id_control = 22'h3FFFFF;
        adder_in   = 32'd0;

        // Reset held with all-ones input: everything stays zero, even across edges.
        #1;
        chk_all_zero("rst_t1");
        #2;
        chk_all_zero("rst_t3");
        tick();
        chk_all_zero("rst_edge");

        @(negedge clk);
        id_control = 22'h000000;
        reset      = 1'b1;

        // Adder is combinational: results appear with no clock edge.
        adder_in = 32'h0000_0000;
        #1;
        chk("add_zero", adder_out, 32'h0000_0004);
        adder_in = 32'h0000_0100;
        #1;
        chk("add_0100", adder_out, 32'h0000_0104);
        adder_in = 32'hFFFF_FFFC;
        #1;
        chk("add_wrap", adder_out, 32'h0000_0000);

        // Single word through both stages.
        id_control = 22'h2AAAAA;
        tick();
        id_control = 22'h000000;
        chk("sw_ex_control", {10'd0, ex_control}, 32'h002A_AAAA);
        chk("sw_ex_src_op",  {29'd0, ex_source_operand}, 32'd5);
        chk("sw_ex_alu_op",  {28'd0, ex_alu_op}, 32'd5);
        chk("sw_ex_rf_en",   {31'd0, ex_rf_enable}, 32'd1);
        chk("sw_ex_branch",  {31'd0, ex_branch_instr}, 32'd0);
        chk("sw_ex_load",    {31'd0, ex_load_instr}, 32'd0);
        chk("sw_mem_before", {10'd0, mem_control}, 32'd0);
        tick();
        chk("sw_mem_control", {10'd0, mem_control}, 32'h0000_022A);
        chk("sw_mem_size",    {30'd0, mem_size}, 32'd1);
        chk("sw_mem_se",      {31'd0, mem_se}, 32'd1);
        chk("sw_mem_rw",      {31'd0, mem_rw}, 32'd0);
        chk("sw_mem_enable",  {31'd0, mem_enable}, 32'd0);
        chk("sw_mem_rf_en",   {31'd0, mem_rf_enable}, 32'd1);
        chk("sw_mem_load",    {31'd0, mem_load_instr}, 32'd0);
        chk("sw_ex_after2",   {10'd0, ex_control}, 32'd0);
        tick();
        chk("sw_ex_after3",  {10'd0, ex_control}, 32'd0);
        chk("sw_mem_after3", {10'd0, mem_control}, 32'd0);

        // Back-to-back words.
        id_control = 22'h155555;
        tick();
        chk("b2b_ex_first", {10'd0, ex_control}, 32'h0015_5555);
        id_control = 22'h2AAAAA;
        tick();
        chk("b2b_ex_control",  {10'd0, ex_control}, 32'h002A_AAAA);
        chk("b2b_mem_control", {10'd0, mem_control}, 32'h0000_0455);

        // Reset pulse between edges discards both in-flight words immediately.
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        id_control = 22'h3FFFFF;
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("mid_rst_rel");
        tick();
        chk("mid_reload_ex",  {10'd0, ex_control}, 32'h003F_FFFF);
        chk("mid_reload_mem", {10'd0, mem_control}, 32'd0);

        // Bubbles after nonzero traffic drain the pipe.
        id_control = 22'h000000;
        tick();
        chk("bub1_ex",  {10'd0, ex_control}, 32'd0);
        chk("bub1_mem", {10'd0, mem_control}, 32'h0000_067F);
        tick();
        chk("bub2_ex",  {10'd0, ex_control}, 32'd0);
        chk("bub2_mem", {10'd0, mem_control}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
